// File: rtl/fixed_point_pkg.sv
// fixed_point_pkg: shared Q-format types and helpers for the neuron datapath
package fixed_point_pkg;
  localparam int INTEGER_BITS = 16;
  localparam int FRACTION_BITS = 16;
  localparam int W = INTEGER_BITS + FRACTION_BITS;
  typedef logic signed [INTEGER_BITS-1:-FRACTION_BITS] fixed_t;
  typedef logic signed [2*W-1:0] product_t;
  typedef logic signed [2*W+31:0] wide_t;
  typedef enum logic [2:0] {ST_IDLE, ST_FETCH, ST_DRAIN, ST_BIAS, ST_OUTPUT} state_t;
  localparam fixed_t FX_ONE = fixed_t'(1 << FRACTION_BITS);
  // Rescale a 2F-fraction accumulator to the word format, flooring and clamping
  function automatic fixed_t saturate(input wide_t acc);
    wide_t s, hi, lo;
    s = acc >>> FRACTION_BITS;
    hi = (wide_t'(1) <<< (W - 1)) - 1;
    lo = -hi - 1;
    return s > hi ? fixed_t'(hi) : s < lo ? fixed_t'(lo) : fixed_t'(s);
  endfunction
  function automatic fixed_t relu(input fixed_t x);
    return x[INTEGER_BITS-1] ? '0 : x;
  endfunction
endpackage

// File: rtl/mac_unit.sv
// mac_unit: registered signed multiply-accumulate holding the wide neuron accumulator
module mac_unit import fixed_point_pkg::*; #(
  parameter int ACC_W = 2 * W + 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    enable,
  input  fixed_t                  a,
  input  fixed_t                  b,
  output logic signed [ACC_W-1:0] acc_q
);
  logic signed [ACC_W-1:0] acc_d;
  product_t product;
  always_comb begin
    product = product_t'(a) * product_t'(b);
    acc_d = clear ? '0 : enable ? acc_q + ACC_W'(product) : acc_q;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) acc_q <= '0;
    else acc_q <= acc_d;
  end
endmodule

// File: rtl/neuron_mac.sv
// neuron_mac: sequences ROM/buffer reads, accumulates, biases, rescales, saturates and activates
module neuron_mac import fixed_point_pkg::*; #(
  parameter int     NUM_INPUTS = 10,
  parameter fixed_t BIAS       = '0,
  parameter         ACTIVATION = "relu",
  localparam int    AW         = $clog2(NUM_INPUTS)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          read_enable,
  output logic [AW-1:0] address,
  input  fixed_t        input_value,
  input  fixed_t        weight_value,
  output fixed_t        output_value
);
  localparam int ACC_W    = 2 * W + AW + 1;
  localparam bit USE_RELU = ACTIVATION == "relu";
  state_t state_q, state_d;
  logic busy_q, busy_d, done_q, done_d, read_enable_q, read_enable_d, data_valid_q, last;
  logic [AW-1:0] address_q, address_d;
  fixed_t output_value_q, output_value_d, saturated;
  logic signed [ACC_W-1:0] acc;
  // Bias is folded in through the multiplier as BIAS x 1.0, landing at 2F fraction bits
  mac_unit #(.ACC_W(ACC_W)) u_mac (
    .clock(clock),
    .reset(reset),
    .clear(state_q == ST_OUTPUT),
    .enable(data_valid_q || state_q == ST_BIAS),
    .a(state_q == ST_BIAS ? BIAS : input_value),
    .b(state_q == ST_BIAS ? FX_ONE : weight_value),
    .acc_q(acc)
  );
  assign last = address_q == AW'(NUM_INPUTS - 1);
  assign saturated = saturate(wide_t'(acc));
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      read_enable_q  <= 1'b0;
      data_valid_q   <= 1'b0;
      address_q      <= '0;
      output_value_q <= '0;
    end else begin
      state_q        <= state_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      read_enable_q  <= read_enable_d;
      data_valid_q   <= read_enable_q;
      address_q      <= address_d;
      output_value_q <= output_value_d;
    end
  end
  always_comb begin
    state_d = state_q == ST_IDLE  ? (start ? ST_FETCH : ST_IDLE) :
              state_q == ST_FETCH ? (last ? ST_DRAIN : ST_FETCH) :
              state_q == ST_DRAIN ? ST_BIAS :
              state_q == ST_BIAS  ? ST_OUTPUT : ST_IDLE;
  end
  always_comb begin
    read_enable_d  = state_q == ST_IDLE ? start : state_q == ST_FETCH && !last;
    address_d      = state_q == ST_IDLE && start ? '0 :
                     state_q == ST_FETCH && !last ? address_q + AW'(1) : address_q;
    busy_d         = state_q == ST_IDLE ? start : state_q != ST_OUTPUT;
    done_d         = state_q == ST_OUTPUT;
    output_value_d = state_q == ST_OUTPUT ? (USE_RELU ? relu(saturated) : saturated) : output_value_q;
  end
  assign busy         = busy_q;
  assign done         = done_q;
  assign read_enable  = read_enable_q;
  assign address      = address_q;
  assign output_value = output_value_q;
endmodule

// File: tb/tb_neuron_mac.sv
// tb_neuron_mac: table-driven and randomized checks of four neuron_mac configurations
module tb_neuron_mac;
  typedef struct packed {
    logic [3:0][31:0] in;
    logic [3:0][31:0] w;
    logic [3:0][31:0] exp;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic busy [4], done [4], re [4];
  logic [1:0] addr [4];
  logic [31:0] outv [4], in_d [4], w_d [4], in_mem [4], w_mem [4];
  int checks = 0, errors = 0;
  vec_t vecs [7];
  always #5 clk = ~clk;
  // Registered-read models of the weight ROM and input buffer, one per instance
  always @(posedge clk)
    for (int k = 0; k < 4; k++)
      if (re[k]) begin
        in_d[k] <= in_mem[addr[k]];
        w_d[k]  <= w_mem[addr[k]];
      end
  // dut0: bias 0 relu, dut1: bias 0.25 relu, dut2: bias 0.25 none, dut3: bias 0 none
  neuron_mac #(.NUM_INPUTS(4), .BIAS(32'h0), .ACTIVATION("relu")) dut0 (
    .clock(clk), .reset(rst), .start(start), .busy(busy[0]), .done(done[0]), .read_enable(re[0]),
    .address(addr[0]), .input_value(in_d[0]), .weight_value(w_d[0]), .output_value(outv[0]));
  neuron_mac #(.NUM_INPUTS(4), .BIAS(32'h4000), .ACTIVATION("relu")) dut1 (
    .clock(clk), .reset(rst), .start(start), .busy(busy[1]), .done(done[1]), .read_enable(re[1]),
    .address(addr[1]), .input_value(in_d[1]), .weight_value(w_d[1]), .output_value(outv[1]));
  neuron_mac #(.NUM_INPUTS(4), .BIAS(32'h4000), .ACTIVATION("none")) dut2 (
    .clock(clk), .reset(rst), .start(start), .busy(busy[2]), .done(done[2]), .read_enable(re[2]),
    .address(addr[2]), .input_value(in_d[2]), .weight_value(w_d[2]), .output_value(outv[2]));
  neuron_mac #(.NUM_INPUTS(4), .BIAS(32'h0), .ACTIVATION("none")) dut3 (
    .clock(clk), .reset(rst), .start(start), .busy(busy[3]), .done(done[3]), .read_enable(re[3]),
    .address(addr[3]), .input_value(in_d[3]), .weight_value(w_d[3]), .output_value(outv[3]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] i0, ir, w0, wr, e0, e1, e2, e3);
    vec_t v;
    v.in  = {ir, ir, ir, i0};
    v.w   = {wr, wr, wr, w0};
    v.exp = {e3, e2, e1, e0};
    return v;
  endfunction

  // Exact real-valued neuron: sum, add bias, floor to 2^-16, clamp, optional relu
  function automatic logic [31:0] model(input vec_t v, input int k);
    logic signed [127:0] acc, q, lim;
    acc = 128'sd0;
    for (int i = 0; i < 4; i++) acc += 128'($signed(v.in[i])) * 128'($signed(v.w[i]));
    if (k == 1 || k == 2) acc += 128'sd16384 * 128'sd65536;
    q = acc / 128'sd65536;
    if (acc < 128'sd0 && q * 128'sd65536 != acc) q -= 128'sd1;
    lim = 128'sd1 <<< 31;
    if (q >= lim) q = lim - 128'sd1;
    else if (q < -lim) q = -lim;
    if (k < 2 && q < 128'sd0) q = 128'sd0;
    return q[31:0];
  endfunction

  task automatic load(input vec_t v);
    for (int i = 0; i < 4; i++) begin
      in_mem[i] = v.in[i];
      w_mem[i]  = v.w[i];
    end
  endtask

  task automatic run(input string name, input vec_t v);
    int cyc, nre;
    load(v);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cyc = 0;
    nre = 0;
    check({name, " busy"}, 32'(busy[0]), 32'd1);
    while (!done[0] && cyc < 40) begin
      if (re[0]) begin
        check({name, " addr"}, 32'(addr[0]), 32'(nre));
        nre++;
      end
      @(negedge clk);
      cyc++;
    end
    check({name, " latency"}, 32'(cyc), 32'd7);
    check({name, " re cycles"}, 32'(nre), 32'd4);
    check({name, " busy end"}, 32'(busy[0]), 32'd0);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s done%0d", name, k), 32'(done[k]), 32'd1);
      check($sformatf("%s out%0d", name, k), outv[k], v.exp[k]);
    end
    @(negedge clk);
    check({name, " done pulse"}, 32'(done[0]), 32'd0);
  endtask

  initial begin
    int dcnt, d1, d2;
    vecs[0] = mk(32'h0001_0000, 32'h0001_0000, 32'h0000_8000, 32'h0000_8000,
                 32'h0002_0000, 32'h0002_4000, 32'h0002_4000, 32'h0002_0000);
    vecs[1] = mk(32'h0001_0000, 32'h0001_0000, 32'hFFFF_0000, 32'hFFFF_0000,
                 32'h0, 32'h0, 32'hFFFC_4000, 32'hFFFC_0000);
    vecs[2] = mk(32'h00C8_0000, 32'h00C8_0000, 32'h00C8_0000, 32'h00C8_0000,
                 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    vecs[3] = mk(32'h00C8_0000, 32'h00C8_0000, 32'hFF38_0000, 32'hFF38_0000,
                 32'h0, 32'h0, 32'h8000_0000, 32'h8000_0000);
    vecs[4] = mk(32'hFFFE_8000, 32'h0, 32'h0000_8000, 32'h0,
                 32'h0, 32'h0, 32'hFFFF_8000, 32'hFFFF_4000);
    vecs[5] = mk(32'h0000_0001, 32'h0, 32'h0000_8000, 32'h0,
                 32'h0, 32'h0000_4000, 32'h0000_4000, 32'h0);
    vecs[6] = mk(32'hFFFF_FFFF, 32'h0, 32'h0000_8000, 32'h0,
                 32'h0, 32'h0000_3FFF, 32'h0000_3FFF, 32'hFFFF_FFFF);
    @(negedge clk);
    @(negedge clk);
    check("reset busy", 32'(busy[0]), 32'd0);
    check("reset done", 32'(done[0]), 32'd0);
    check("reset re", 32'(re[0]), 32'd0);
    check("reset addr", 32'(addr[0]), 32'd0);
    check("reset out", outv[0], 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 7; i++) run($sformatf("vec%0d", i), vecs[i]);

    // Asynchronous reset three cycles into FETCH
    load(vecs[0]);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async busy", 32'(busy[0]), 32'd0);
    check("async re", 32'(re[0]), 32'd0);
    check("async done", 32'(done[0]), 32'd0);
    check("async out3", outv[3], 32'd0);
    @(negedge clk) rst = 1'b0;
    run("after reset", vecs[0]);

    // Starts while busy are ignored; start during done is accepted
    load(vecs[0]);
    dcnt = 0;
    d1 = -1;
    d2 = -1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int c = 0; c < 24; c++) begin
      if (done[0]) begin
        dcnt++;
        if (dcnt == 1) d1 = c;
        else d2 = c;
      end
      start = c == 2 || c == 4 || (done[0] && dcnt == 1);
      @(negedge clk);
    end
    start = 1'b0;
    check("b2b done count", 32'(dcnt), 32'd2);
    check("b2b first done", 32'(d1), 32'd7);
    check("b2b second done", 32'(d2), 32'd15);
    check("b2b out", outv[0], 32'h0002_0000);

    for (int n = 0; n < 24; n++) begin
      vec_t v;
      for (int i = 0; i < 4; i++) begin
        v.in[i] = n < 12 ? $urandom_range(32'h000F_FFFF, 0) - 32'h0008_0000 : $urandom;
        v.w[i]  = n < 12 ? $urandom_range(32'h000F_FFFF, 0) - 32'h0008_0000 : $urandom;
      end
      for (int k = 0; k < 4; k++) v.exp[k] = model(v, k);
      run($sformatf("rand%0d", n), v);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/neuron_mac.md
Name: neuron_mac

Overview:
- Fixed-point neuron stage that sits directly downstream of the weight ROM.
- On start, it walks indices 0..NUM_INPUTS-1, driving address and enable to the weight ROM and to the layer input buffer. Both memories have a 1-cycle registered read.
- It multiply-accumulates input×weight at full precision, adds a constant bias, rescales, saturates, and optionally applies ReLU.
- The result is presented to the next layer with a one-cycle done pulse.

Parameters:
- INTEGER_BITS, 16, integer bits of signed fixed-point word (sign bit included).
- FRACTION_BITS, 16, fractional bits; word width W = INTEGER_BITS+FRACTION_BITS.
- NUM_INPUTS, 10, number of inputs/weights; legal range ≥ 2.
- BIAS, 0, signed W-bit bias in the same Q format.
- ACTIVATION, "relu", "relu" or "none".

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request one evaluation; sampled only in IDLE.
- busy  output  1  high from the edge after start is accepted until done.
- done  output  1  one-cycle pulse when output_value is updated.
- read_enable  output  1  enable to weight ROM and input buffer.
- address  output  $clog2(NUM_INPUTS)  shared index to weight ROM and input buffer.
- input_value  input  W signed  input buffer data, valid 1 cycle after address/read_enable.
- weight_value  input  W signed  weight ROM data, valid 1 cycle after address/read_enable.
- output_value  output  W signed  neuron result; held until next done.

Behaviour:
- Interface decision: one clock, port clock; reset is asynchronous and active-high, port reset.
- All outputs are registered.
- Reset values: busy=0, done=0, read_enable=0, address=0, output_value=0, accumulator=0, state=IDLE.
- FSM states: IDLE, FETCH, DRAIN, BIAS, OUTPUT.
- IDLE:
  - start=1 at edge E0 → FETCH, address=0, read_enable=1, busy=1.
- FETCH:
  - Each edge increments address.
  - At the edge where address==NUM_INPUTS-1: read_enable→0 and state→DRAIN; address holds its last value.
  - Exactly NUM_INPUTS enabled cycles are issued.
- Data-valid tracking:
  - data_valid is read_enable delayed by 1 cycle.
  - On each edge with data_valid=1: accumulator += input_value × weight_value.
  - The product is the full 2W-bit signed product with 2×FRACTION_BITS fraction bits.
- DRAIN: one cycle to accumulate the last product → BIAS.
- BIAS: accumulator += BIAS sign-extended and shifted left by FRACTION_BITS → OUTPUT.
- OUTPUT:
  - result = accumulator >>> FRACTION_BITS (arithmetic shift, truncation toward −∞).
  - Saturate to [−2^(W−1), 2^(W−1)−1].
  - If ACTIVATION=="relu" and result<0, output 0.
  - Register output_value, pulse done=1, busy→0, clear accumulator, → IDLE.
- Latency: done is high in the cycle following edge E0+NUM_INPUTS+3.
- Accumulator width: 2W + $clog2(NUM_INPUTS) + 1. No intermediate overflow is possible.
- start while busy: ignored; no queueing.
- start in the same cycle as done: the core is already in IDLE on that edge, so start is accepted. Back-to-back evaluations are legal.
- reset mid-operation: immediate return to reset values; partial sum discarded; no done.
- output_value changes only on done or reset.

Decomposition:
- Shared package fixed_point_pkg holds:
  - parameters INTEGER_BITS, FRACTION_BITS;
  - typedef fixed_t = logic signed [INTEGER_BITS-1:-FRACTION_BITS];
  - typedef product_t (2W signed);
  - function saturate(wide accumulator) → fixed_t;
  - function relu(fixed_t) → fixed_t.
- One natural sub-module, mac_unit:
  - registered multiply-accumulate with clear and accumulate-enable;
  - holds the wide accumulator;
  - isolates DSP inference.
- FSM and address counter stay in neuron_mac.

Test Plan:
- NUM_INPUTS=4, inputs all 1.0 (0x0001_0000), weights all 0.5 (0x0000_8000), BIAS=0 → output_value 0x0002_0000. done pulses exactly 7 cycles after start edge; read_enable high exactly 4 cycles; address 0,1,2,3.
- NUM_INPUTS=4, inputs 1.0, weights −1.0, BIAS=0.25:
  - with ACTIVATION="relu" → 0x0000_0000;
  - with ACTIVATION="none" → −3.75 = 0xFFFC_4000.
- Saturation, NUM_INPUTS=4, inputs 200.0, weights 200.0 → 0x7FFF_FFFF. Same with weights −200.0 and ACTIVATION="none" → 0x8000_0000.
- Assert reset 3 cycles into FETCH → busy/done/read_enable/output_value all 0 immediately (asynchronous). Next start with the first test's stimulus yields 0x0002_0000 (no stale partial sum).
- Pulse start again at cycles 2 and 4 of an evaluation → ignored, single done. Then assert start in the done cycle → second evaluation accepted; second done exactly NUM_INPUTS+4 cycles after first done.
- Fractional truncation: one nonzero product −1.5×0.5, others 0, ACTIVATION="none" → 0xFFFF_4000. Also one product of 2^−16 × 0.5 → 0x0000_0000 (floor toward −∞), and −2^−16 × 0.5 → 0xFFFF_FFFF.
